// File: rtl/dino_motion_ctrl.sv
// Dinosaur sprite motion: keypad decode, 64-step jump trajectory on game tick,
// and frame-synchronous display latch of the sprite X/Y position.
module dino_motion_ctrl #(
  parameter int X_INIT   = 320,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 512,
  parameter int GROUND_Y = 240,
  parameter int STEP_X   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_ready,
  input  logic [4:0] key_code,
  input  logic       frame_sync,
  output logic [9:0] dino_x,
  output logic [8:0] dino_y,
  output logic       airborne,
  output logic [5:0] step
);

  typedef enum logic [1:0] {IDLE, RISE, FALL, DROP} state_t;

  localparam logic [8:0] GY      = 9'(GROUND_Y);
  localparam logic [4:0] K_JUMP  = 5'h10;
  localparam logic [4:0] K_LEFT  = 5'h0C;
  localparam logic [4:0] K_RIGHT = 5'h0E;
  localparam logic [4:0] K_DROP  = 5'h11;

  state_t      state_q, state_d;
  logic [5:0]  step_q, step_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [8:0]  pos_y_q, pos_y_d;
  logic        key_q;
  logic [9:0]  dino_x_q, dino_x_d;
  logic [8:0]  dino_y_q, dino_y_d;
  logic        key_evt;
  logic [9:0]  y_sum;
  logic [10:0] x_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= 6'd0;
      pos_x_q  <= 10'(X_INIT);
      pos_y_q  <= GY;
      key_q    <= 1'b0;
      dino_x_q <= 10'(X_INIT);
      dino_y_q <= GY;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      key_q    <= key_ready;
      dino_x_q <= dino_x_d;
      dino_y_q <= dino_y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dino_x_d = dino_x_q;
    dino_y_d = dino_y_q;
    key_evt  = key_ready & ~key_q;
    y_sum    = {1'b0, pos_y_q} + 10'd8;
    x_sum    = {1'b0, pos_x_q} + 11'(STEP_X);

    // Tick is evaluated against the pre-key state; key effects layer on top.
    if (tick) begin
      case (state_q)
        IDLE: pos_y_d = GY;
        RISE: begin
          if (step_q < 6'd10)      pos_y_d = pos_y_q - 9'd8;
          else if (step_q < 6'd20) pos_y_d = pos_y_q - 9'd4;
          else                     pos_y_d = pos_y_q - 9'd2;
          step_d = step_q + 6'd1;
          if (step_q == 6'd31) state_d = FALL;
        end
        FALL: begin
          if (step_q == 6'd63) begin
            pos_y_d = GY;
            state_d = IDLE;
            step_d  = 6'd0;
          end else begin
            if (step_q < 6'd44)      pos_y_d = pos_y_q + 9'd2;
            else if (step_q < 6'd54) pos_y_d = pos_y_q + 9'd4;
            else                     pos_y_d = pos_y_q + 9'd8;
            step_d = step_q + 6'd1;
          end
        end
        DROP: begin
          if (y_sum >= {1'b0, GY}) begin
            pos_y_d = GY;
            state_d = IDLE;
            step_d  = 6'd0;
          end else begin
            pos_y_d = y_sum[8:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (key_evt) begin
      case (key_code)
        K_JUMP: if (state_q == IDLE) begin
          state_d = RISE;
          step_d  = 6'd0;
        end
        K_DROP: if (state_q == RISE || state_q == FALL) state_d = DROP;
        K_LEFT: begin
          if ({1'b0, pos_x_q} >= 11'(X_MIN + STEP_X)) pos_x_d = pos_x_q - 10'(STEP_X);
          else                                        pos_x_d = 10'(X_MIN);
        end
        K_RIGHT: begin
          if (x_sum <= 11'(X_MAX)) pos_x_d = x_sum[9:0];
          else                     pos_x_d = 10'(X_MAX);
        end
        default: ;
      endcase
    end

    if (frame_sync) begin
      dino_x_d = pos_x_q;
      dino_y_d = pos_y_q;
    end
  end

  assign dino_x   = dino_x_q;
  assign dino_y   = dino_y_q;
  assign airborne = (state_q != IDLE);
  assign step     = (state_q == IDLE) ? 6'd0 : step_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed bench for dino_motion_ctrl: jump trajectory, X clamping, drop,
// key-edge detection, key/tick coincidence and mid-jump reset.
module tb_dino_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       key_ready;
  logic [4:0] key_code;
  logic       frame_sync;
  logic [9:0] dino_x;
  logic [8:0] dino_y;
  logic       airborne;
  logic [5:0] step;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dino_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .frame_sync (frame_sync),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .airborne   (airborne),
    .step       (step)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one clock cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic t, input logic kr, input logic [4:0] kc, input logic fs);
    @(negedge clk);
    tick       = t;
    key_ready  = kr;
    key_code   = kc;
    frame_sync = fs;
    @(posedge clk);
    #1;
    tick       = 1'b0;
    key_ready  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic key(input logic [4:0] kc);
    cyc(1'b0, 1'b1, kc, 1'b0);
    cyc(1'b0, 1'b0, kc, 1'b0);
  endtask

  task automatic do_tick();
    cyc(1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic frame();
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  // Hand-derived jump height after n ticks, piecewise by segment.
  function automatic int exp_y(input int n);
    if (n <= 10)      return 240 - 8 * n;
    else if (n <= 20) return 160 - 4 * (n - 10);
    else if (n <= 32) return 120 - 2 * (n - 20);
    else if (n <= 44) return 96 + 2 * (n - 32);
    else if (n <= 54) return 120 + 4 * (n - 44);
    else              return 160 + 8 * (n - 54);
  endfunction

  initial begin
    rst = 1'b1; tick = 1'b0; key_ready = 1'b0; key_code = 5'd0; frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(dino_x), 320);
    check("rst_y", 32'(dino_y), 240);
    rst = 1'b0;
    frame();
    check("init_x", 32'(dino_x), 320);
    check("init_y", 32'(dino_y), 240);
    check("init_air", 32'(airborne), 0);
    check("init_step", 32'(step), 0);

    // Full jump with a second jump request ignored at tick 20.
    key(5'h10);
    check("jump_air", 32'(airborne), 1);
    for (int n = 1; n <= 64; n++) begin
      do_tick();
      if (n == 20) key(5'h10);
      frame();
      check($sformatf("jump_y%0d", n), 32'(dino_y), 32'(exp_y(n)));
      check($sformatf("jump_air%0d", n), 32'(airborne), (n < 64) ? 1 : 0);
      check($sformatf("jump_step%0d", n), 32'(step), (n < 64) ? 32'(n) : 0);
    end
    check("apex_calc", 32'(exp_y(32)), 96);

    // X clamping at both edges.
    for (int i = 0; i < 9; i++) key(5'h0E);
    frame();
    check("right9_x", 32'(dino_x), 500);
    for (int i = 0; i < 8; i++) key(5'h0E);
    frame();
    check("right17_x", 32'(dino_x), 512);
    for (int i = 0; i < 25; i++) key(5'h0C);
    frame();
    check("left25_x", 32'(dino_x), 12);
    for (int i = 0; i < 2; i++) key(5'h0C);
    frame();
    check("left27_x", 32'(dino_x), 0);

    // Drop from y=160.
    key(5'h10);
    repeat (10) do_tick();
    frame();
    check("pre_drop_y", 32'(dino_y), 160);
    key(5'h11);
    check("drop_air", 32'(airborne), 1);
    repeat (9) do_tick();
    frame();
    check("drop9_y", 32'(dino_y), 232);
    check("drop9_air", 32'(airborne), 1);
    do_tick();
    frame();
    check("drop10_y", 32'(dino_y), 240);
    check("drop10_air", 32'(airborne), 0);
    check("drop10_step", 32'(step), 0);
    key(5'h11);
    do_tick();
    frame();
    check("idle_drop_air", 32'(airborne), 0);
    check("idle_drop_y", 32'(dino_y), 240);

    // Held key_ready yields one event only.
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 5'h0E, 1'b0);
    cyc(1'b0, 1'b0, 5'h0E, 1'b1);
    check("held_key_x", 32'(dino_x), 20);

    // Jump coincident with tick: no motion until the next tick.
    cyc(1'b1, 1'b1, 5'h10, 1'b0);
    frame();
    check("coinc_y0", 32'(dino_y), 240);
    check("coinc_air", 32'(airborne), 1);
    check("coinc_step0", 32'(step), 0);
    do_tick();
    frame();
    check("coinc_y1", 32'(dino_y), 232);
    check("coinc_step1", 32'(step), 1);

    // Reset mid-jump at step 25.
    repeat (24) do_tick();
    frame();
    check("pre_rst_step", 32'(step), 25);
    check("pre_rst_y", 32'(dino_y), 110);
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_y", 32'(dino_y), 240);
    check("mid_rst_x", 32'(dino_x), 320);
    check("mid_rst_air", 32'(airborne), 0);
    check("mid_rst_step", 32'(step), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
